// File: rtl/seg_pkg.sv
// Shared constants and width helper for the 7-segment scan controller.
package seg_pkg;

  localparam int SUB_SLOTS = 16;
  localparam int SUB_W     = 4;
  localparam int SEG_W_MAX = 64;

  // All-ones pattern, sliced to the real segment width where used.
  localparam logic [SEG_W_MAX-1:0] SEG_BLANK = '1;

  // Counter width for a modulus of n, never below one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Scan timebase: prescaler, brightness sub-slot counter and digit index.
module seg_scan_tick
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DIV      = 2,
  parameter int IDX_W    = width_of(N_DIGITS),
  parameter int PRESC_W  = width_of(DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             tick,
  output logic [SUB_W-1:0] sub,
  output logic [IDX_W-1:0] idx,
  output logic             frame_start
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(SUB_SLOTS - 1);

  logic [PRESC_W-1:0] presc;

  assign tick        = (presc == PRESC_LAST);
  assign frame_start = tick && (sub == SUB_LAST) && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      sub   <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        sub <= sub + 1'b1;
        // idx only moves once all 16 brightness sub-slots of a digit are done
        if (sub == SUB_LAST)
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Frame-buffered N-digit 7-segment scan controller with PWM brightness and blanking.
// Optional per-digit blinking is compiled in when SEG_BLINK_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SEG_W    = 8,
  parameter int DIV      = 2,
  parameter int BLINK_FR = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_DIGITS*SEG_W-1:0] digits,
  input  logic [N_DIGITS-1:0]       blank_mask,
  input  logic [3:0]                brightness,
`ifdef SEG_BLINK_EN
  input  logic [N_DIGITS-1:0]       blink_mask,
`endif
  output logic [SEG_W-1:0]          seg,
  output logic [N_DIGITS-1:0]       seg_en,
  output logic                      frame
);

  localparam int IDX_W = width_of(N_DIGITS);
  localparam logic [SEG_W-1:0] BLANK = SEG_BLANK[SEG_W-1:0];

  logic                           tick;
  logic                           frame_start;
  logic                           reload;
  logic [SUB_W-1:0]               sub;
  logic [IDX_W-1:0]               idx;
  logic [N_DIGITS-1:0][SEG_W-1:0] shadow;
  logic                           blink_hide;
  logic                           lit;
  logic [N_DIGITS-1:0]            en_next;
  logic [SEG_W-1:0]               seg_next;

  seg_scan_tick #(
    .N_DIGITS (N_DIGITS),
    .DIV      (DIV),
    .IDX_W    (IDX_W)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .sub         (sub),
    .idx         (idx),
    .frame_start (frame_start)
  );

  assign reload = tick && frame_start;

`ifdef SEG_BLINK_EN
  localparam int BFR_W = width_of(BLINK_FR);
  localparam logic [BFR_W-1:0] BFR_LAST = BFR_W'(BLINK_FR - 1);

  logic [BFR_W-1:0] bfr_cnt;
  logic             blink_on;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bfr_cnt  <= '0;
      blink_on <= 1'b1;
    end else if (reload) begin
      if (bfr_cnt == BFR_LAST) begin
        bfr_cnt  <= '0;
        blink_on <= ~blink_on;
      end else begin
        bfr_cnt <= bfr_cnt + 1'b1;
      end
    end
  end

  assign blink_hide = !blink_on && blink_mask[idx];
`else
  assign blink_hide = 1'b0;
`endif

  // brightness and blank_mask act live so a change lands on the very next output update
  assign lit = (sub <= brightness) && !blank_mask[idx] && !blink_hide;

  always_comb begin
    en_next = '1;
    for (int k = 0; k < N_DIGITS; k++)
      if (lit && (idx == IDX_W'(k)))
        en_next[N_DIGITS-1-k] = 1'b0;
    seg_next = lit ? shadow[idx] : BLANK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= {N_DIGITS{BLANK}};
      seg    <= BLANK;
      seg_en <= '1;
      frame  <= 1'b0;
    end else begin
      // seg/seg_en come from the pre-reload shadow, so the frame boundary is clean
      if (reload)
        shadow <= digits;
      seg    <= seg_next;
      seg_en <= en_next;
      frame  <= reload;
    end
  end

endmodule
